// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit (one result bit per cycle) feeding the register-file write port.
// Optional `MULDIV_EARLY_OUT_EN: data-dependent early termination, variable latency, identical results.
module muldiv_unit #(
    parameter int unsigned ARCH_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic                  isWord,
    input  logic [ARCH_WIDTH-1:0] op1,
    input  logic [ARCH_WIDTH-1:0] op2,
    input  logic [4:0]            rdIn,
    output logic                  busy,
    output logic                  done,
    output logic                  wEn,
    output logic [4:0]            rdOut,
    output logic [ARCH_WIDTH-1:0] result
);
    localparam int unsigned XW = ARCH_WIDTH;
    localparam int unsigned HW = XW / 2;
    localparam int unsigned PW = 2 * XW;
    localparam int unsigned CW = 7;
    localparam logic [CW-1:0] N_DW = CW'(XW);
    localparam logic [CW-1:0] N_W  = CW'(HW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [XW-1:0] f_sext_w(input logic [HW-1:0] v);
        return {{HW{v[HW-1]}}, v};
    endfunction

`ifdef MULDIV_EARLY_OUT_EN
    function automatic logic [CW-1:0] f_lzc(input logic [XW-1:0] v);
        logic [CW-1:0] n;
        logic          hit;
        n   = '0;
        hit = 1'b0;
        for (int i = XW - 1; i >= 0; i--) begin
            if (v[i]) hit = 1'b1;
            else if (!hit) n = n + CW'(1);
        end
        return n;
    endfunction
`endif

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_f3;
    logic            r_word;
    logic            r_neg;
    logic            r_rneg;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_mcd;
    logic [XW-1:0]   r_mpl;
    logic [XW-1:0]   r_quo;
    logic [XW-1:0]   r_rem;
    logic [XW-1:0]   r_div;
    logic            r_busy;
    logic            r_done;
    logic            r_wen;
    logic [4:0]      r_rd;
    logic [XW-1:0]   r_result;

    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic [XW-1:0]   w_a_ext;
    logic [XW-1:0]   w_b_ext;
    logic [XW-1:0]   w_min;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XW-1:0]   w_a_mag;
    logic [XW-1:0]   w_b_mag;
    logic            w_illegal;
    logic            w_div0;
    logic            w_ovf;
    logic            w_fast;
    logic [XW-1:0]   w_fast_res;
    logic [CW-1:0]   w_n;
    logic [XW-1:0]   w_q_init;
    logic [CW-1:0]   w_div_cnt;
    logic [XW-1:0]   w_div_q;
`ifdef MULDIV_EARLY_OUT_EN
    logic [CW-1:0]   w_lz;
`endif

    logic            w_mul_end;
    logic [PW-1:0]   w_acc_nxt;
    logic [PW-1:0]   w_prod;
    logic [XW-1:0]   w_mul_res;
    logic [XW:0]     w_rem_sh;
    logic [XW:0]     w_diff;
    logic [XW-1:0]   w_rem_nxt;
    logic [XW-1:0]   w_quo_nxt;
    logic [XW-1:0]   w_q_fix;
    logic [XW-1:0]   w_r_fix;
    logic [XW-1:0]   w_div_res;

    assign busy   = r_busy;
    assign done   = r_done;
    assign wEn    = r_wen;
    assign rdOut  = r_rd;
    assign result = r_result;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Operand conditioning, fast-path detection and iteration setup for a new request
    always_comb begin
        w_is_div   = funct3[2];
        w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        w_a_ext    = op1;
        w_b_ext    = op2;
        w_min      = {1'b1, {(XW-1){1'b0}}};
        if (isWord) begin
            // Only signed W divides sign-extend; MULW zero-extends so 32 steps cover the multiplier
            w_a_ext = w_b_signed ? f_sext_w(op1[HW-1:0]) : {{HW{1'b0}}, op1[HW-1:0]};
            w_b_ext = w_b_signed ? f_sext_w(op2[HW-1:0]) : {{HW{1'b0}}, op2[HW-1:0]};
            w_min   = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
        end
        w_a_neg    = w_a_signed && w_a_ext[XW-1];
        w_b_neg    = w_b_signed && w_b_ext[XW-1];
        w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
        w_illegal  = isWord && !w_is_div && (funct3[1:0] != 2'b00);
        w_div0     = w_is_div && (w_b_ext == '0);
        w_ovf      = w_is_div && !funct3[0] && (w_a_ext == w_min) && (w_b_ext == '1);
        w_fast     = w_illegal || w_div0 || w_ovf;
        w_fast_res = '0;
        if (w_div0)     w_fast_res = funct3[1] ? w_a_ext : '1;
        else if (w_ovf) w_fast_res = funct3[1] ? '0 : w_min;
        if (isWord)     w_fast_res = f_sext_w(w_fast_res[HW-1:0]);
        w_n        = isWord ? N_W : N_DW;
        w_q_init   = isWord ? {w_a_mag[HW-1:0], {HW{1'b0}}} : w_a_mag;
        w_div_cnt  = w_n - CW'(1);
        w_div_q    = w_q_init;
`ifdef MULDIV_EARLY_OUT_EN
        // Leading dividend zeros only shift zeros into the quotient; keep at least one step
        w_lz       = f_lzc(w_q_init);
        if (w_lz > w_n - CW'(1)) w_lz = w_n - CW'(1);
        w_div_cnt  = w_n - CW'(1) - w_lz;
        w_div_q    = w_q_init << w_lz;
`endif
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_end = (r_cnt == '0) || (r_mpl[XW-1:1] == '0);
`else
    assign w_mul_end = (r_cnt == '0);
`endif

    // One shift-add / restoring step, plus the sign fix-up applied on the final step
    always_comb begin
        w_acc_nxt = r_acc + (r_mpl[0] ? r_mcd : '0);
        w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
        w_mul_res = (r_f3[1:0] == 2'b00) ? w_prod[XW-1:0] : w_prod[PW-1:XW];
        w_rem_sh  = {r_rem, r_quo[XW-1]};
        w_diff    = w_rem_sh - {1'b0, r_div};
        if (!w_diff[XW]) begin
            w_rem_nxt = w_diff[XW-1:0];
            w_quo_nxt = {r_quo[XW-2:0], 1'b1};
        end else begin
            w_rem_nxt = w_rem_sh[XW-1:0];
            w_quo_nxt = {r_quo[XW-2:0], 1'b0};
        end
        w_q_fix   = r_neg ? -w_quo_nxt : w_quo_nxt;
        w_r_fix   = r_rneg ? -w_rem_nxt : w_rem_nxt;
        w_div_res = r_f3[1] ? w_r_fix : w_q_fix;
        if (r_word) begin
            w_mul_res = f_sext_w(w_mul_res[HW-1:0]);
            w_div_res = f_sext_w(w_div_res[HW-1:0]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (w_fast)        w_state_nxt = S_DONE;
                    else if (w_is_div) w_state_nxt = S_DIV;
                    else               w_state_nxt = S_MUL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL:   if (w_mul_end) w_state_nxt = S_DONE;
            S_DIV:   if (r_cnt == '0) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f3     <= '0;
            r_word   <= 1'b0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcd    <= '0;
            r_mpl    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wen    <= 1'b0;
            r_rd     <= '0;
            r_result <= '0;
        end else begin
            r_busy <= (w_state_nxt == S_MUL) || (w_state_nxt == S_DIV);
            r_done <= (w_state_nxt == S_DONE);
            r_wen  <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_f3   <= funct3;
                r_word <= isWord;
                r_rd   <= rdIn;
                r_neg  <= w_a_neg ^ w_b_neg;
                r_rneg <= w_a_neg;
                r_acc  <= '0;
                r_mcd  <= {{XW{1'b0}}, w_a_mag};
                r_mpl  <= w_b_mag;
                r_rem  <= '0;
                r_div  <= w_b_mag;
                r_quo  <= w_div_q;
                r_cnt  <= w_is_div ? w_div_cnt : (w_n - CW'(1));
                if (w_fast) r_result <= w_fast_res;
            end else if (r_state == S_MUL) begin
                r_acc <= w_acc_nxt;
                r_mcd <= r_mcd << 1;
                r_mpl <= r_mpl >> 1;
                r_cnt <= r_cnt - CW'(1);
                if (w_mul_end) r_result <= w_mul_res;
            end else if (r_state == S_DIV) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == '0) r_result <= w_div_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        start  = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic        isWord = 1'b0;
    logic [63:0] op1    = 64'd0;
    logic [63:0] op2    = 64'd0;
    logic [4:0]  rdIn   = 5'd0;
    logic        busy;
    logic        done;
    logic        wEn;
    logic [4:0]  rdOut;
    logic [63:0] result;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .isWord (isWord),
        .op1    (op1),
        .op2    (op2),
        .rdIn   (rdIn),
        .busy   (busy),
        .done   (done),
        .wEn    (wEn),
        .rdOut  (rdOut),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RV64M semantics written directly from the ISA rules
    function automatic logic [63:0] ref_res(input logic [2:0] f, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, sub;
        logic [127:0]        p;
        logic [63:0]         r;
        logic [31:0]         a32, b32, t;
        sa  = $signed({{64{a[63]}}, a});
        sb  = $signed({{64{b[63]}}, b});
        sub = $signed({64'd0, b});
        a32 = a[31:0];
        b32 = b[31:0];
        t   = 32'd0;
        r   = 64'd0;
        if (w) begin
            case (f)
                3'b000: t = a32 * b32;
                3'b100: begin
                    if (b32 == 32'd0) t = 32'hFFFF_FFFF;
                    else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) t = 32'h8000_0000;
                    else t = $signed(a32) / $signed(b32);
                end
                3'b101: begin
                    if (b32 == 32'd0) t = 32'hFFFF_FFFF;
                    else t = a32 / b32;
                end
                3'b110: begin
                    if (b32 == 32'd0) t = a32;
                    else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) t = 32'd0;
                    else t = $signed(a32) % $signed(b32);
                end
                3'b111: begin
                    if (b32 == 32'd0) t = a32;
                    else t = a32 % b32;
                end
                default: t = 32'd0;
            endcase
            return {{32{t[31]}}, t};
        end
        case (f)
            3'b000: begin p = {64'd0, a} * {64'd0, b}; r = p[63:0]; end
            3'b001: begin p = sa * sb;  r = p[127:64]; end
            3'b010: begin p = sa * sub; r = p[127:64]; end
            3'b011: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
            3'b100: begin
                if (b == 64'd0) r = ONES;
                else if (a == MIN64 && b == ONES) r = MIN64;
                else r = $signed(a) / $signed(b);
            end
            3'b101: r = (b == 64'd0) ? ONES : a / b;
            3'b110: begin
                if (b == 64'd0) r = a;
                else if (a == MIN64 && b == ONES) r = 64'd0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 64'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit ref_fast(input logic [2:0] f, input logic w,
                                    input logic [63:0] a, input logic [63:0] b);
        if (w && (f == 3'b001 || f == 3'b010 || f == 3'b011)) return 1'b1;
        if (!f[2]) return 1'b0;
        if (w) return (b[31:0] == 32'd0) ||
                      (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) || (!f[0] && a == MIN64 && b == ONES);
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return ONES;
            2:       return MIN64;
            3:       return 64'h0000_0000_8000_0000;
            4:       return 64'($urandom_range(0, 300));
            5:       return -64'($urandom_range(1, 300));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Caller is positioned at a negedge with the unit idle or in its done cycle
    task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input bit poke);
        logic [63:0] exp_res;
        int          exp_lat;
        int          lat;
        bit          seen;
        bit          busy_ok;
        exp_res = ref_res(f, w, a, b);
        exp_lat = ref_fast(f, w, a, b) ? 1 : (w ? 33 : 65);
        funct3 = f; isWord = w; op1 = a; op2 = b; rdIn = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op1    = {$urandom, $urandom};
        op2    = {$urandom, $urandom};
        rdIn   = 5'($urandom);
        funct3 = 3'($urandom);
        isWord = 1'($urandom);
        seen = 1'b0; busy_ok = 1'b1; lat = 0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
            start = poke && !EARLY && (c == 5);
        end
        start = 1'b0;
        check({tag, "/done"},     64'(seen),    64'd1);
        check({tag, "/result"},   result,       exp_res);
        check({tag, "/rd"},       64'(rdOut),   64'(rd));
        check({tag, "/wEn"},      64'(wEn),     64'd1);
        check({tag, "/busy_end"}, 64'(busy),    64'd0);
        check({tag, "/busy_run"}, 64'(busy_ok), 64'd1);
`ifdef MULDIV_EARLY_OUT_EN
        check({tag, "/lat"}, 64'(lat >= 1 && lat <= exp_lat), 64'd1);
`else
        check({tag, "/lat"}, 64'(lat), 64'(exp_lat));
`endif
    endtask

    task automatic idle(input int n, input string tag);
        bit spur;
        spur = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || wEn || busy) spur = 1'b1;
        end
        check({tag, "/idle"}, 64'(spur), 64'd0);
    endtask

    initial begin
        bit spur;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/busy",   64'(busy),  64'd0);
        check("rst/done",   64'(done),  64'd0);
        check("rst/wEn",    64'(wEn),   64'd0);
        check("rst/rdOut",  64'(rdOut), 64'd0);
        check("rst/result", result,     64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul",      3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1'b0);
        check("mul/value", result, 64'hFFFF_FFFF_FFFF_FFEB);
        idle(2, "mul");
        run_op("mulhu",    3'b011, 1'b0, ONES, ONES, 5'd1, 1'b0);
        run_op("mulh",     3'b001, 1'b0, ONES, ONES, 5'd2, 1'b0);
        run_op("div",      3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd3, 1'b0);
        run_op("rem",      3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd4, 1'b0);
        run_op("divw_ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, ONES, 5'd6, 1'b0);
        check("divw_ovf/value", result, 64'hFFFF_FFFF_8000_0000);
        idle(1, "ovf");
        run_op("divu0",    3'b101, 1'b0, 64'd123, 64'd0, 5'd7, 1'b0);
        run_op("remu0",    3'b111, 1'b0, 64'd123, 64'd0, 5'd8, 1'b0);
        run_op("mulh_ill", 3'b001, 1'b1, 64'd55, 64'd66, 5'd9, 1'b0);
        idle(2, "fast");

        // Back-to-back accept from DONE, with an ignored start while busy
        run_op("mulw",     3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd10, 1'b1);
        run_op("b2b_divu", 3'b101, 1'b0, 64'd1000, 64'd7, 5'd11, 1'b1);
        idle(2, "b2b");

        // Reset in the middle of a divide
        funct3 = 3'b100; isWord = 1'b0; op1 = 64'hFFFF_FFFF_FFFF_FC18; op2 = 64'd7; rdIn = 5'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort/busy",   64'(busy),  64'd0);
        check("abort/done",   64'(done),  64'd0);
        check("abort/wEn",    64'(wEn),   64'd0);
        check("abort/rdOut",  64'(rdOut), 64'd0);
        check("abort/result", result,     64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spur = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done || wEn || busy) spur = 1'b1;
        end
        check("abort/no_done", 64'(spur), 64'd0);
        run_op("post_rst", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 5'd12, 1'b0);

        for (int k = 0; k < 40; k++) begin
            logic [2:0]  f;
            logic        w;
            logic [63:0] a;
            logic [63:0] b;
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            run_op($sformatf("rnd%0d_f%0d_w%0d", k, f, w), f, w, a, b, 5'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) idle(1, "rnd");
        end

        idle(2, "end");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
